// File: rtl/ex_comp_buffer_pkg.sv
// Shared types and defaults for the EX/COMP completion buffer.
package ex_comp_buffer_pkg;

   localparam int unsigned ROB_IDX_BITS   = 5;
   localparam int unsigned COMP_N         = 2;
   localparam int unsigned COMP_NUM_FU    = 4;
   localparam int unsigned COMP_BUF_DEPTH = 8;

   // One completed FU result as held in the queue and presented on an output lane.
   typedef struct packed {
      logic [ROB_IDX_BITS-1:0] rob_idx;
      logic                    mispredict;
      logic                    branch_valid;
      logic                    branch_taken;
      logic [31:0]             branch_target;
   } comp_entry_t;

   localparam int unsigned COMP_ENTRY_W = $bits(comp_entry_t);

   // Builds a queue entry; branch outcome fields are only meaningful for branches,
   // so they are zeroed otherwise to keep downstream comparisons clean.
   function automatic comp_entry_t make_entry(
      input logic [ROB_IDX_BITS-1:0] rob_idx,
      input logic                    mispredict,
      input logic                    branch_valid,
      input logic                    branch_taken,
      input logic [31:0]             branch_target
   );
      comp_entry_t e;
      e               = '0;
      e.rob_idx       = rob_idx;
      e.mispredict    = mispredict;
      e.branch_valid  = branch_valid;
      e.branch_taken  = branch_valid & branch_taken;
      e.branch_target = branch_valid ? branch_target : '0;
      return e;
   endfunction

endpackage

// File: rtl/ex_comp_buffer_fifo.sv
// Circular FIFO with WR_PORTS sparse write ports (compacted in port order)
// and RD_PORTS read lanes popping min(count, RD_PORTS) oldest entries per cycle.
module multi_port_fifo #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned WR_PORTS = 4,
   parameter int unsigned RD_PORTS = 2
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                clear,
   input  logic [WR_PORTS-1:0]                 wr_en,
   input  logic [WR_PORTS-1:0][WIDTH-1:0]      wr_data,
   output logic [RD_PORTS-1:0]                 rd_valid,
   output logic [RD_PORTS-1:0][WIDTH-1:0]      rd_data,
   output logic [$clog2(DEPTH+1)-1:0]          count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0]                mem [DEPTH];
   logic [PTR_W-1:0]                head;
   logic [PTR_W-1:0]                tail;
   logic [CNT_W-1:0]                enq_cnt;
   logic [CNT_W-1:0]                deq_cnt;
   logic [WR_PORTS-1:0][PTR_W-1:0]  wr_ptr;

   // Compaction: each active write port lands at tail plus the number of active lower ports.
   always_comb begin
      enq_cnt = '0;
      wr_ptr  = '0;
      for (int unsigned i = 0; i < WR_PORTS; i++) begin
         wr_ptr[i] = tail + PTR_W'(enq_cnt);
         enq_cnt   = enq_cnt + CNT_W'(wr_en[i]);
      end
   end

   // Read side: the oldest min(count, RD_PORTS) entries, pointer arithmetic wraps naturally.
   always_comb begin
      deq_cnt  = (count < CNT_W'(RD_PORTS)) ? count : CNT_W'(RD_PORTS);
      rd_valid = '0;
      rd_data  = '0;
      for (int unsigned j = 0; j < RD_PORTS; j++) begin
         rd_valid[j] = CNT_W'(j) < deq_cnt;
         rd_data[j]  = mem[head + PTR_W'(j)];
      end
   end

   // Storage write; contents need no reset because validity is tracked by count.
   always_ff @(posedge clock) begin
      if (!clear) begin
         for (int unsigned i = 0; i < WR_PORTS; i++) begin
            if (wr_en[i]) mem[wr_ptr[i]] <= wr_data[i];
         end
      end
   end

   // Pointer and occupancy update; clear squashes both enqueue and dequeue of this cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(deq_cnt);
         tail  <= tail + PTR_W'(enq_cnt);
         count <= count + enq_cnt - deq_cnt;
      end
   end

endmodule

// File: rtl/ex_comp_buffer.sv
// Collects FU results into an in-order queue and issues up to N per cycle
// into the registered EX/COMP boundary; a flush drops everything in flight.
module ex_comp_buffer
   import ex_comp_buffer_pkg::*;
#(
   parameter int unsigned N      = COMP_N,
   parameter int unsigned NUM_FU = COMP_NUM_FU,
   parameter int unsigned DEPTH  = COMP_BUF_DEPTH
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  flush,
   input  logic [NUM_FU-1:0]                     fu_valid,
   input  logic [NUM_FU-1:0][ROB_IDX_BITS-1:0]   fu_rob_idx,
   input  logic [NUM_FU-1:0]                     fu_mispredict,
   input  logic [NUM_FU-1:0]                     fu_branch_valid,
   input  logic [NUM_FU-1:0]                     fu_branch_taken,
   input  logic [NUM_FU-1:0][31:0]               fu_branch_target,
   output logic                                  fu_ready,
   output logic [N-1:0]                          ex_valid_out,
   output comp_entry_t [N-1:0]                   ex_comp_out,
   output logic [$clog2(DEPTH+1)-1:0]            occupancy
);

   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [NUM_FU-1:0]         wr_en;
   comp_entry_t [NUM_FU-1:0]  wr_entry;
   logic [N-1:0]              rd_valid;
   comp_entry_t [N-1:0]       rd_entry;
   logic [CNT_W-1:0]          count;

   // Room for a full FU burst is judged from state only, never from fu_valid.
   assign fu_ready  = (32'(count) + NUM_FU) <= DEPTH;
   assign occupancy = count;

   // Accept results only when there is room and no squash is in progress.
   always_comb begin
      wr_en    = fu_valid & {NUM_FU{fu_ready & ~flush}};
      wr_entry = '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         wr_entry[i] = make_entry(fu_rob_idx[i], fu_mispredict[i], fu_branch_valid[i],
                                  fu_branch_taken[i], fu_branch_target[i]);
      end
   end

   multi_port_fifo #(
      .WIDTH    (COMP_ENTRY_W),
      .DEPTH    (DEPTH),
      .WR_PORTS (NUM_FU),
      .RD_PORTS (N)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .clear    (flush),
      .wr_en    (wr_en),
      .wr_data  (wr_entry),
      .rd_valid (rd_valid),
      .rd_data  (rd_entry),
      .count    (count)
   );

   // Output register; idle lanes are forced to all-zero fields.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ex_valid_out <= '0;
         ex_comp_out  <= '0;
      end else if (flush) begin
         ex_valid_out <= '0;
         ex_comp_out  <= '0;
      end else begin
         ex_valid_out <= rd_valid;
         for (int unsigned j = 0; j < N; j++) begin
            ex_comp_out[j] <= rd_valid[j] ? rd_entry[j] : '0;
         end
      end
   end

endmodule

// File: tb/tb_ex_comp_buffer.sv
// Scoreboard bench: a queue-based reference model pushes the expected per-cycle
// output at every edge; a monitor pops and compares on the opposite edge.
module tb_ex_comp_buffer;
   import ex_comp_buffer_pkg::*;

   localparam int unsigned N      = 2;
   localparam int unsigned NUM_FU = 4;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned OCC_W  = $clog2(DEPTH+1);

   logic                                clock = 1'b0;
   logic                                reset = 1'b1;
   logic                                flush = 1'b0;
   logic [NUM_FU-1:0]                   fu_valid = '0;
   logic [NUM_FU-1:0][ROB_IDX_BITS-1:0] fu_rob_idx = '0;
   logic [NUM_FU-1:0]                   fu_mispredict = '0;
   logic [NUM_FU-1:0]                   fu_branch_valid = '0;
   logic [NUM_FU-1:0]                   fu_branch_taken = '0;
   logic [NUM_FU-1:0][31:0]             fu_branch_target = '0;
   logic                                fu_ready;
   logic [N-1:0]                        ex_valid_out;
   comp_entry_t [N-1:0]                 ex_comp_out;
   logic [OCC_W-1:0]                    occupancy;

   always #5 clock = ~clock;

   ex_comp_buffer #(.N(N), .NUM_FU(NUM_FU), .DEPTH(DEPTH)) dut (
      .clock            (clock),
      .reset            (reset),
      .flush            (flush),
      .fu_valid         (fu_valid),
      .fu_rob_idx       (fu_rob_idx),
      .fu_mispredict    (fu_mispredict),
      .fu_branch_valid  (fu_branch_valid),
      .fu_branch_taken  (fu_branch_taken),
      .fu_branch_target (fu_branch_target),
      .fu_ready         (fu_ready),
      .ex_valid_out     (ex_valid_out),
      .ex_comp_out      (ex_comp_out),
      .occupancy        (occupancy)
   );

   typedef struct {
      logic [N-1:0]        valid;
      comp_entry_t [N-1:0] lanes;
      int unsigned         occ;
      logic                ready;
   } exp_t;

   exp_t        sb_q[$];
   comp_entry_t model_q[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
      end
   endfunction

   function automatic bit model_ready();
      return (DEPTH - model_q.size()) >= NUM_FU;
   endfunction

   // Reference model: a plain in-order queue advanced once per rising edge.
   initial begin
      exp_t        e;
      comp_entry_t x;
      int unsigned sz, deq;
      bit          rdy;
      forever begin
         @(posedge clock);
         e.valid = '0;
         e.lanes = '0;
         if (reset || flush) begin
            model_q.delete();
         end else begin
            sz  = model_q.size();
            rdy = (DEPTH - sz) >= NUM_FU;
            deq = (sz < N) ? sz : N;
            for (int unsigned j = 0; j < deq; j++) begin
               e.valid[j] = 1'b1;
               e.lanes[j] = model_q.pop_front();
            end
            if (rdy) begin
               for (int unsigned i = 0; i < NUM_FU; i++) begin
                  if (fu_valid[i]) begin
                     x               = '0;
                     x.rob_idx       = fu_rob_idx[i];
                     x.mispredict    = fu_mispredict[i];
                     x.branch_valid  = fu_branch_valid[i];
                     if (fu_branch_valid[i]) begin
                        x.branch_taken  = fu_branch_taken[i];
                        x.branch_target = fu_branch_target[i];
                     end
                     model_q.push_back(x);
                  end
               end
            end
         end
         e.occ   = model_q.size();
         e.ready = (DEPTH - e.occ) >= NUM_FU;
         sb_q.push_back(e);
      end
   end

   // Monitor: compares the registered outputs against the oldest expected record.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow at %0t: actual=empty required=record", $time);
         end else begin
            e = sb_q.pop_front();
            if (reset) begin
               e.valid = '0;
               e.lanes = '0;
               e.occ   = 0;
               e.ready = 1'b1;
            end
            check("ex_valid_out", 128'(ex_valid_out), 128'(e.valid));
            check("ex_comp_out",  128'(ex_comp_out),  128'(e.lanes));
            check("occupancy",    128'(occupancy),    128'(e.occ));
            check("fu_ready",     128'(fu_ready),     128'(e.ready));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout at %0t: actual=running required=finished", $time);
      $fatal(1, "timeout");
   end

   task automatic rand_fields();
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         fu_rob_idx[i]       = ROB_IDX_BITS'($urandom);
         fu_mispredict[i]    = 1'($urandom_range(0, 1));
         fu_branch_valid[i]  = 1'($urandom_range(0, 1));
         fu_branch_taken[i]  = 1'($urandom_range(0, 1));
         fu_branch_target[i] = $urandom;
      end
   endtask

   task automatic set_fu(input int unsigned i, input logic [ROB_IDX_BITS-1:0] rob,
                         input logic mp, input logic bv, input logic bt, input logic [31:0] tgt);
      fu_rob_idx[i]       = rob;
      fu_mispredict[i]    = mp;
      fu_branch_valid[i]  = bv;
      fu_branch_taken[i]  = bt;
      fu_branch_target[i] = tgt;
   endtask

   // Drives one cycle of FU traffic; results are only offered while the buffer has room.
   task automatic apply(input logic [NUM_FU-1:0] v, input logic fl);
      @(negedge clock);
      fu_valid = (model_ready() || fl) ? v : '0;
      flush    = fl;
   endtask

   initial begin
      // reset then idle
      apply('0, 1'b0);
      apply('0, 1'b0);
      #1 reset = 1'b0;
      repeat (10) apply('0, 1'b0);

      // single result on FU1
      rand_fields();
      set_fu(1, 5'd5, 1'b0, 1'b1, 1'b1, 32'h1000);
      apply(4'b0010, 1'b0);
      repeat (3) apply('0, 1'b0);

      // burst wider than N
      rand_fields();
      set_fu(0, 5'd3, 1'b0, 1'b0, 1'b1, 32'hdead);
      set_fu(1, 5'd7, 1'b1, 1'b1, 1'b0, 32'h2000);
      set_fu(2, 5'd9, 1'b0, 1'b1, 1'b1, 32'h3000);
      set_fu(3, 5'd12, 1'b1, 1'b0, 1'b0, 32'hbeef);
      apply(4'hF, 1'b0);
      repeat (4) apply('0, 1'b0);

      // backpressure: full bursts three cycles running
      for (int k = 0; k < 3; k++) begin
         rand_fields();
         apply(4'hF, 1'b0);
      end
      repeat (8) apply('0, 1'b0);

      // wrap-around: clear pointers, move head/tail to 6, then straddle the end
      apply('0, 1'b1);
      rand_fields(); apply(4'hF, 1'b0);
      rand_fields(); apply(4'b0011, 1'b0);
      repeat (2) apply('0, 1'b0);
      rand_fields(); apply(4'hF, 1'b0);
      repeat (4) apply('0, 1'b0);

      // flush with five queued and FUs valid
      rand_fields(); apply(4'hF, 1'b0);
      rand_fields(); apply(4'b0111, 1'b0);
      rand_fields(); apply(4'hF, 1'b1);
      repeat (3) apply('0, 1'b0);

      // asynchronous reset mid-burst
      rand_fields(); apply(4'hF, 1'b0);
      rand_fields(); apply(4'hF, 1'b0);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("async_rst_valid", 128'(ex_valid_out), 128'(0));
      check("async_rst_comp",  128'(ex_comp_out),  128'(0));
      check("async_rst_occ",   128'(occupancy),    128'(0));
      apply('0, 1'b0);
      apply('0, 1'b0);
      #1 reset = 1'b0;

      // randomized traffic with occasional flushes and idle stretches
      for (int k = 0; k < 400; k++) begin
         rand_fields();
         apply(($urandom_range(0, 3) == 0) ? '0 : NUM_FU'($urandom),
               $urandom_range(0, 39) == 0);
      end
      repeat (8) apply('0, 1'b0);

      @(negedge clock);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
